// File: rtl/hazard_flush_unit.sv
// Pipeline hazard/flush controller: load-use stalls, branch/jump squashes,
// memory-wait freeze with watchdog, and saturating stall/flush event counters.
module hazard_flush_unit #(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       ID_rs,
  input  logic [4:0]       ID_rt,
  input  logic             ID_uses_rt,
  input  logic             ID_jump,
  input  logic             EX_MemRead,
  input  logic [4:0]       EX_rt,
  input  logic             EX_branch_taken,
  input  logic             mem_busy,
  input  logic             clear_cnt,
  output logic             PC_write,
  output logic             IF_ID_write,
  output logic             pipe_hold,
  output logic             stall_flush,
  output logic             IF_ID_flush,
  output logic             ID_flush,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WCNT_W = ($clog2(MEM_TIMEOUT + 1) < 7) ? 7 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WCNT_W-1:0] WMAX = WCNT_W'(MEM_TIMEOUT);

  typedef enum logic {RUN, MEM_WAIT} state_e;

  state_e             state_q, state_d;
  logic [WCNT_W-1:0]  wcnt_q, wcnt_d;
  logic               mem_timeout_q, mem_timeout_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;
  logic               lu;
  logic               stall_ev, flush_ev;

  // r0 is never a real destination, so a load targeting it cannot create a hazard
  assign lu = EX_MemRead && (EX_rt != 5'd0) &&
              ((EX_rt == ID_rs) || (ID_uses_rt && (EX_rt == ID_rt)));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= RUN;
      wcnt_q        <= '0;
      mem_timeout_q <= 1'b0;
      stall_cnt_q   <= '0;
      flush_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      wcnt_q        <= wcnt_d;
      mem_timeout_q <= mem_timeout_d;
      stall_cnt_q   <= stall_cnt_d;
      flush_cnt_q   <= flush_cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    wcnt_d        = wcnt_q;
    mem_timeout_d = mem_timeout_q;
    case (state_q)
      RUN: begin
        if (mem_busy) begin
          state_d = MEM_WAIT;
          wcnt_d  = WCNT_W'(1);
        end else begin
          wcnt_d  = '0;
        end
      end
      MEM_WAIT: begin
        if (mem_busy) begin
          if (wcnt_q != WMAX) wcnt_d = wcnt_q + WCNT_W'(1);
        end else begin
          state_d = RUN;
          wcnt_d  = '0;
        end
      end
      default: begin
        state_d = RUN;
        wcnt_d  = '0;
      end
    endcase
    // Flag lands on the edge where the busy run reaches the limit
    if (mem_busy && (wcnt_d == WMAX)) mem_timeout_d = 1'b1;
  end

  always_comb begin
    PC_write    = 1'b1;
    IF_ID_write = 1'b1;
    pipe_hold   = 1'b0;
    stall_flush = 1'b0;
    IF_ID_flush = 1'b0;
    ID_flush    = 1'b0;
    stall_ev    = 1'b0;
    flush_ev    = 1'b0;
    if (reset) begin
      PC_write    = 1'b0;
      IF_ID_write = 1'b0;
      IF_ID_flush = 1'b1;
      ID_flush    = 1'b1;
    end else if (mem_busy) begin
      PC_write    = 1'b0;
      IF_ID_write = 1'b0;
      pipe_hold   = 1'b1;
      stall_ev    = 1'b1;
    end else if (EX_branch_taken) begin
      IF_ID_flush = 1'b1;
      ID_flush    = 1'b1;
      flush_ev    = 1'b1;
    end else if (lu) begin
      // a coincident jump waits; it is seen again once the bubble clears the hazard
      PC_write    = 1'b0;
      IF_ID_write = 1'b0;
      stall_flush = 1'b1;
      stall_ev    = 1'b1;
    end else if (ID_jump) begin
      IF_ID_flush = 1'b1;
      flush_ev    = 1'b1;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (clear_cnt) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (stall_ev && (stall_cnt_q != {CNT_W{1'b1}})) stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if (flush_ev && (flush_cnt_q != {CNT_W{1'b1}})) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  assign mem_timeout = mem_timeout_q;
  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_hazard_flush_unit.sv
// Randomized + directed bench for hazard_flush_unit against a priority-rule
// reference model (busy run length, sticky watchdog, clamped integer counters).
module tb_hazard_flush_unit;
  localparam int CNT_W = 4;
  localparam int MT    = 64;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic reset, ID_uses_rt, ID_jump, EX_MemRead, EX_branch_taken, mem_busy, clear_cnt;
  logic [4:0] ID_rs, ID_rt, EX_rt;
  logic PC_write, IF_ID_write, pipe_hold, stall_flush, IF_ID_flush, ID_flush, mem_timeout;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int m_run = 0, m_sc = 0, m_fc = 0;
  bit m_to = 1'b0;

  always #5 clk = ~clk;

  hazard_flush_unit #(.CNT_W(CNT_W), .MEM_TIMEOUT(MT)) dut (
    .clk(clk), .reset(reset), .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_uses_rt(ID_uses_rt),
    .ID_jump(ID_jump), .EX_MemRead(EX_MemRead), .EX_rt(EX_rt),
    .EX_branch_taken(EX_branch_taken), .mem_busy(mem_busy), .clear_cnt(clear_cnt),
    .PC_write(PC_write), .IF_ID_write(IF_ID_write), .pipe_hold(pipe_hold),
    .stall_flush(stall_flush), .IF_ID_flush(IF_ID_flush), .ID_flush(ID_flush),
    .mem_timeout(mem_timeout), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // 0 none, 1 freeze, 2 branch, 3 load-use, 4 jump, 5 reset
  function automatic int event_of();
    bit hz;
    hz = EX_MemRead && EX_rt != 0 && (EX_rt == ID_rs || (ID_uses_rt && EX_rt == ID_rt));
    if (reset) return 5;
    if (mem_busy) return 1;
    if (EX_branch_taken) return 2;
    if (hz) return 3;
    if (ID_jump) return 4;
    return 0;
  endfunction

  // {PC_write, IF_ID_write, pipe_hold, stall_flush, IF_ID_flush, ID_flush}
  function automatic logic [5:0] ctl_of(input int ev);
    case (ev)
      1: return 6'b001000;
      2: return 6'b110011;
      3: return 6'b000100;
      4: return 6'b110010;
      5: return 6'b000011;
      default: return 6'b110000;
    endcase
  endfunction

  task automatic step(input string tag);
    int ev;
    #2;
    ev = event_of();
    chk({tag, ".ctl"}, {26'd0, PC_write, IF_ID_write, pipe_hold, stall_flush, IF_ID_flush, ID_flush},
        {26'd0, ctl_of(ev)});
    @(posedge clk);
    if (reset) begin
      m_run = 0; m_to = 0; m_sc = 0; m_fc = 0;
    end else begin
      if (mem_busy) begin
        m_run = (m_run < MT) ? m_run + 1 : MT;
        if (m_run == MT) m_to = 1;
      end else m_run = 0;
      if (clear_cnt) begin
        m_sc = 0; m_fc = 0;
      end else begin
        if ((ev == 1 || ev == 3) && m_sc < MAXC) m_sc++;
        if ((ev == 2 || ev == 4) && m_fc < MAXC) m_fc++;
      end
    end
    #1;
    chk({tag, ".scnt"}, 32'(stall_cnt), 32'(m_sc));
    chk({tag, ".fcnt"}, 32'(flush_cnt), 32'(m_fc));
    chk({tag, ".to"}, 32'(mem_timeout), 32'(m_to));
  endtask

  task automatic idle();
    reset = 0; ID_rs = 0; ID_rt = 0; ID_uses_rt = 0; ID_jump = 0; EX_MemRead = 0;
    EX_rt = 0; EX_branch_taken = 0; mem_busy = 0; clear_cnt = 0;
  endtask

  task automatic do_reset();
    idle(); reset = 1; step("rst"); reset = 0;
  endtask

  initial begin
    idle();
    // reset held two cycles against a busy memory and taken branch
    reset = 1; mem_busy = 1; EX_branch_taken = 1;
    step("rst0"); step("rst1");
    chk("rst_iff", 32'(IF_ID_flush), 1);
    chk("rst_pc", 32'(PC_write), 0);
    idle(); #1;
    chk("rst_scnt", 32'(stall_cnt), 0);
    chk("rst_to", 32'(mem_timeout), 0);

    // load-use and its non-stalling variants
    EX_MemRead = 1; EX_rt = 8; ID_rs = 8; step("lu");
    chk("lu_scnt", 32'(stall_cnt), 1);
    EX_rt = 0; ID_rs = 0; step("lu_r0");
    EX_rt = 8; ID_rs = 3; ID_rt = 8; ID_uses_rt = 0; step("lu_nort");
    chk("lu_nort_scnt", 32'(stall_cnt), 1);

    // branch beats load-use
    do_reset();
    EX_MemRead = 1; EX_rt = 8; ID_rs = 8; EX_branch_taken = 1; step("brlu");
    chk("brlu_fcnt", 32'(flush_cnt), 1);
    chk("brlu_scnt", 32'(stall_cnt), 0);

    // jump deferred behind load-use bubble
    do_reset();
    EX_MemRead = 1; EX_rt = 8; ID_rs = 8; ID_jump = 1; step("jd1");
    chk("jd1_sf", 32'(stall_flush), 1);
    EX_MemRead = 0; step("jd2");
    chk("jd2_iff", 32'(IF_ID_flush), 1);
    chk("jd2_fcnt", 32'(flush_cnt), 1);

    // freeze with held branch, then branch acts on release
    do_reset();
    EX_branch_taken = 1; mem_busy = 1;
    repeat (3) step("frz");
    chk("frz_scnt", 32'(stall_cnt), 3);
    mem_busy = 0; step("frz_rel");
    chk("frz_fcnt", 32'(flush_cnt), 1);

    // watchdog and stall counter saturation
    do_reset();
    mem_busy = 1;
    repeat (MT - 1) step("wd");
    chk("wd_pre", 32'(mem_timeout), 0);
    step("wd_hit");
    chk("wd_hit1", 32'(mem_timeout), 1);
    mem_busy = 0; step("wd_drop");
    chk("wd_sticky", 32'(mem_timeout), 1);
    do_reset();
    EX_MemRead = 1; EX_rt = 5; ID_rs = 5;
    repeat (20) step("sat");
    chk("sat_scnt", 32'(stall_cnt), MAXC);
    clear_cnt = 1; step("clr");
    chk("clr_scnt", 32'(stall_cnt), 0);

    // random traffic with small register ranges to provoke hazards
    for (int i = 0; i < 3000; i++) begin
      reset           = ($urandom_range(99) < 2);
      mem_busy        = ($urandom_range(99) < 20);
      clear_cnt       = ($urandom_range(99) < 3);
      EX_branch_taken = ($urandom_range(99) < 15);
      ID_jump         = ($urandom_range(99) < 20);
      EX_MemRead      = ($urandom_range(99) < 50);
      ID_uses_rt      = $urandom_range(1);
      EX_rt           = 5'($urandom_range(3));
      ID_rs           = 5'($urandom_range(3));
      ID_rt           = 5'($urandom_range(3));
      step("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/hazard_flush_unit.md
Name: hazard_flush_unit

Overview:
- Generates the stall and flush requests consumed by the ID-stage control-word squash logic (`stall_flush`, `IF_ID_flush`, `ID_flush`).
- Also generates PC/IF-ID write enables and a whole-pipeline hold for multi-cycle data-memory accesses.
- Detection is combinational from ID/EX pipeline fields.
- A small FSM tracks memory-wait freezes and a watchdog timeout; saturating counters record stall cycles and flush events.

Parameters:
- `CNT_W`, 16, width of each performance counter.
- `MEM_TIMEOUT`, 64, maximum consecutive `mem_busy` cycles before `mem_timeout` sets.

Ports:
- `clk  input  1`  system clock, rising edge.
- `reset  input  1`  synchronous, active-high.
- `ID_rs  input  5`  rs field of instruction in ID.
- `ID_rt  input  5`  rt field of instruction in ID.
- `ID_uses_rt  input  1`  ID instruction reads rt as a source.
- `ID_jump  input  1`  ID instruction is j/jal.
- `EX_MemRead  input  1`  EX instruction is a load.
- `EX_rt  input  5`  destination of the load in EX.
- `EX_branch_taken  input  1`  branch in EX resolved taken.
- `mem_busy  input  1`  data memory not ready this cycle.
- `clear_cnt  input  1`  synchronous clear of both counters.
- `PC_write  output  1`  PC update enable.
- `IF_ID_write  output  1`  IF/ID register load enable.
- `pipe_hold  output  1`  hold ID/EX, EX/MEM and MEM/WB registers.
- `stall_flush  output  1`  insert bubble into ID/EX (load-use).
- `IF_ID_flush  output  1`  squash instruction in IF/ID.
- `ID_flush  output  1`  squash control word leaving ID.
- `mem_timeout  output  1`  sticky watchdog error.
- `stall_cnt  output  CNT_W`  stall cycles counted.
- `flush_cnt  output  CNT_W`  flush events counted.

Behaviour:
- **Load-use condition:** `lu = EX_MemRead && EX_rt != 0 && (EX_rt == ID_rs || (ID_uses_rt && EX_rt == ID_rt))`.
- **Per-cycle priority:** (1) freeze, (2) branch, (3) load-use, (4) jump, (5) none. Only the highest active event drives the outputs.
- **Freeze** (`mem_busy=1`, any state):
  - `PC_write=0`, `IF_ID_write=0`, `pipe_hold=1`.
  - All flush outputs 0; `stall_cnt` += 1.
- **Branch:**
  - `PC_write=1`, `IF_ID_write=1`, `IF_ID_flush=1`, `ID_flush=1`.
  - `stall_flush=0`: a coincident load-use is suppressed because the ID instruction is squashed.
  - `flush_cnt` += 1.
- **Load-use:**
  - `PC_write=0`, `IF_ID_write=0`, `stall_flush=1`; other flushes 0.
  - `stall_cnt` += 1.
  - A coincident `ID_jump` is deferred; the jump is re-evaluated the next cycle once the bubble has cleared the hazard.
- **Jump:**
  - `PC_write=1`, `IF_ID_write=1`, `IF_ID_flush=1`, `ID_flush=0`.
  - `flush_cnt` += 1.
- **None:** `PC_write=1`, `IF_ID_write=1`, `pipe_hold=0`, all flushes 0.
- **Latency:** every control output is combinational (zero-cycle) from the inputs and state. Counters, FSM and `mem_timeout` update on the rising clock edge.
- **FSM states:** RUN, MEM_WAIT. A 7-bit-or-wider wait counter `wcnt` is sized to hold `MEM_TIMEOUT`.
  - RUN, `mem_busy=1`: go to MEM_WAIT, `wcnt`=1.
  - MEM_WAIT, `mem_busy=1`: stay; `wcnt` += 1, saturating at `MEM_TIMEOUT`.
  - When `mem_busy=1` and `wcnt==MEM_TIMEOUT`, `mem_timeout` is set (sticky until reset).
  - MEM_WAIT, `mem_busy=0`: go to RUN, `wcnt`=0.
  - The cycle `mem_busy` falls is evaluated as a normal RUN-priority cycle; a held taken branch or load-use acts then.
- **Counters:**
  - Saturate at all-ones (no wrap).
  - `clear_cnt` zeroes both and takes precedence over any increment that cycle.
- **Reset** (synchronous, mid-operation included), registered state on the next edge:
  - state=RUN, `wcnt`=0, `mem_timeout`=0, `stall_cnt`=0, `flush_cnt`=0.
- **Outputs during reset cycles:** forced to `PC_write=0`, `IF_ID_write=0`, `pipe_hold=0`, `stall_flush=0`, `IF_ID_flush=1`, `ID_flush=1` (pipeline squashed), irrespective of other inputs.
- **`EX_rt==0` rule:** never causes a stall.

Test Plan:
- **Reset:** assert `reset` 2 cycles with `mem_busy=1`, `EX_branch_taken=1` → `IF_ID_flush=ID_flush=1`, `PC_write=0`; after release, state RUN, counters 0, `mem_timeout=0`.
- **Load-use:** `EX_MemRead=1`, `EX_rt=8`, `ID_rs=8`, one cycle → `stall_flush=1`, `PC_write=IF_ID_write=0`, `stall_cnt`=1. Repeat with `EX_rt=0` → no stall. Repeat with `ID_rt=8`, `ID_uses_rt=0` → no stall.
- **Branch with coincident load-use:** `EX_branch_taken=1` with the load-use condition true → `IF_ID_flush=ID_flush=1`, `stall_flush=0`, `PC_write=1`, `flush_cnt`=1, `stall_cnt` unchanged.
- **Jump deferred by load-use:** `ID_jump=1` with load-use → cycle 1 `stall_flush=1`, `IF_ID_flush=0`; cycle 2, hazard cleared → `IF_ID_flush=1`, `ID_flush=0`, `flush_cnt`=1.
- **Memory freeze:** `mem_busy=1` for 3 cycles alongside taken branch → `pipe_hold=1`, no flushes, `stall_cnt`=3. On `mem_busy=0` → branch flush fires, FSM back in RUN.
- **Watchdog and saturation:** `mem_busy=1` for `MEM_TIMEOUT`=64 cycles → `mem_timeout=1` from the 64th edge and stays 1 after `mem_busy` drops. With `CNT_W=4`, 20 load-use cycles → `stall_cnt`=15. Then `clear_cnt=1` with a load-use active → `stall_cnt`=0.
